// File: rtl/unpooler.sv
// ============================================================================
//  Module      : unpooler
//  Description : Nearest-neighbour upsampler. Each pooled input value is
//                replicated into a P x P block of an M x M output map.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module unpooler #(
    parameter int M  = 12,
    parameter int P  = 3,
    parameter int DW = 8
) (
    input  logic          clk,
    input  logic          master_rst_n,
    input  logic [DW-1:0] data_in,
    input  logic          valid_in,
    output logic          ready_in,
    input  logic          ce,
    output logic [DW-1:0] data_out,
    output logic          valid_op,
    output logic          end_op
);

    localparam int W     = M / P;
    localparam int REP_W = (P > 1) ? $clog2(P) : 1;
    localparam int COL_W = (W > 1) ? $clog2(W) : 1;

    localparam logic [REP_W-1:0] C_REP_LAST = REP_W'(P - 1);
    localparam logic [COL_W-1:0] C_COL_LAST = COL_W'(W - 1);
    localparam logic [REP_W-1:0] C_REP_ONE  = REP_W'(1);
    localparam logic [COL_W-1:0] C_COL_ONE  = COL_W'(1);

    generate
        if (((M % P) != 0) || (P < 2)) begin : g_bad_params
            $error("unpooler: M must be a multiple of P and P must be >= 2");
        end
    endgenerate

    typedef enum logic [0:0] {
        S_FILL   = 1'b0,
        S_REPLAY = 1'b1
    } state_t;

    state_t            r_state;
    state_t            w_state_nxt;
    logic [REP_W-1:0]  r_rep;
    logic [COL_W-1:0]  r_col;
    logic [REP_W-1:0]  r_row;
    logic [COL_W-1:0]  r_grp;
    logic [DW-1:0]     r_hold;
    logic              r_hold_v;
    logic [DW-1:0]     r_linebuf [0:W-1];

    logic w_valid;
    logic w_consume;
    logic w_rep_last;
    logic w_col_last;
    logic w_row_last;
    logic w_grp_last;
    logic w_col_adv;
    logic w_xfer;

    assign w_rep_last = (r_rep == C_REP_LAST);
    assign w_col_last = (r_col == C_COL_LAST);
    assign w_row_last = (r_row == C_REP_LAST);
    assign w_grp_last = (r_grp == C_COL_LAST);

    // Replay rows always have a pixel ready in the line buffer.
    assign w_valid   = (r_state == S_REPLAY) | r_hold_v;
    assign w_consume = w_valid & ce;
    assign w_col_adv = w_consume & w_rep_last;

    assign valid_op = w_valid;
    assign data_out = (r_state == S_REPLAY) ? r_linebuf[r_col] : r_hold;
    assign end_op   = w_valid & w_grp_last & w_row_last & w_col_last & w_rep_last;
    assign ready_in = master_rst_n & (r_state == S_FILL)
                    & (~r_hold_v | (ce & w_rep_last));
    assign w_xfer   = valid_in & ready_in;

    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_state <= S_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_FILL: begin
                if (w_col_adv && w_col_last) begin
                    w_state_nxt = S_REPLAY;
                end
            end
            S_REPLAY: begin
                if (w_col_adv && w_col_last && w_row_last) begin
                    w_state_nxt = S_FILL;
                end
            end
            default: w_state_nxt = S_FILL;
        endcase
    end

    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_rep <= '0;
            r_col <= '0;
            r_row <= '0;
            r_grp <= '0;
        end else if (w_consume) begin
            if (w_rep_last) begin
                r_rep <= '0;
                r_col <= w_col_last ? '0 : r_col + C_COL_ONE;
                if (w_col_last) begin
                    if (r_state == S_FILL) begin
                        r_row <= C_REP_ONE;
                    end else if (w_row_last) begin
                        r_row <= '0;
                        r_grp <= w_grp_last ? '0 : r_grp + C_COL_ONE;
                    end else begin
                        r_row <= r_row + C_REP_ONE;
                    end
                end
            end else begin
                r_rep <= r_rep + C_REP_ONE;
            end
        end
    end

    // A value accepted on the last pixel of row 0 belongs to the next group;
    // it waits in the hold register through the replay rows.
    always_ff @(posedge clk or negedge master_rst_n) begin
        if (!master_rst_n) begin
            r_hold   <= '0;
            r_hold_v <= 1'b0;
        end else if (w_xfer) begin
            r_hold   <= data_in;
            r_hold_v <= 1'b1;
        end else if (w_col_adv && (r_state == S_FILL)) begin
            r_hold_v <= 1'b0;
        end
    end

    // The line buffer slot tracks the value presented during row 0.
    always_ff @(posedge clk) begin
        if ((r_state == S_FILL) && r_hold_v) begin
            r_linebuf[r_col] <= r_hold;
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_unpooler.sv
// ============================================================================
//  Module      : tb_unpooler
//  Description : Self-checking bench for unpooler (M=12/P=3 and M=4/P=2).
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_unpooler;

    logic       clk = 1'b0;
    logic       master_rst_n = 1'b0;
    logic       ce = 1'b1;
    logic [7:0] data_in = '0,  data_in2 = '0;
    logic       valid_in = 1'b0, valid_in2 = 1'b0;
    logic       ready_in, ready_in2;
    logic [7:0] data_out, data_out2;
    logic       valid_op, valid_op2, end_op, end_op2;

    int n_total = 0;
    int n_bad   = 0;
    int cyc     = 0;
    bit ce_rand = 1'b0;

    logic [8:0] q1[$];
    logic [8:0] q2[$];
    logic [8:0] exp1, exp2;

    int n_pix = 0, n_end = 0, t_first = 0, t_last = 0;
    int rdy_lo = 0, rdy_hi_bad = 0;
    int n_pix2 = 0, n_end2 = 0;
    bit hold_chk = 1'b0;
    logic [7:0] held_data = '0;

    unpooler #(.M(12), .P(3), .DW(8)) dut (
        .clk(clk), .master_rst_n(master_rst_n),
        .data_in(data_in), .valid_in(valid_in), .ready_in(ready_in),
        .ce(ce), .data_out(data_out), .valid_op(valid_op), .end_op(end_op)
    );

    unpooler #(.M(4), .P(2), .DW(8)) dut2 (
        .clk(clk), .master_rst_n(master_rst_n),
        .data_in(data_in2), .valid_in(valid_in2), .ready_in(ready_in2),
        .ce(ce), .data_out(data_out2), .valid_op(valid_op2), .end_op(end_op2)
    );

    always #5 clk = ~clk;

    always begin
        @(posedge clk);
        cyc++;
    end

    always begin
        @(posedge clk);
        #1;
        ce = ce_rand ? 1'($urandom_range(0, 1)) : 1'b1;
    end

    // Monitor for the 12x12 instance: scoreboard, stall stability, ready profile.
    always begin
        @(negedge clk);
        if (!master_rst_n) begin
            hold_chk = 1'b0;
        end else begin
            if (hold_chk) begin
                n_total++;
                assert (valid_op === 1'b1 && data_out === held_data) else begin
                    n_bad++;
                    $error("FAIL stall_hold: observed valid=%0b data=%0d expected valid=1 data=%0d",
                           valid_op, data_out, held_data);
                end
            end
            hold_chk  = valid_op && !ce;
            held_data = data_out;
            if (valid_op && ce) begin
                if (((n_pix % 144) / 12) % 3 != 0) begin
                    if (!ready_in) rdy_lo++;
                    else rdy_hi_bad++;
                end
                n_total++;
                assert (q1.size() != 0) else begin
                    n_bad++;
                    $error("FAIL extra_pixel: observed data=%0d end=%0b expected none", data_out, end_op);
                end
                if (q1.size() != 0) begin
                    exp1 = q1.pop_front();
                    n_total++;
                    assert ({end_op, data_out} === exp1) else begin
                        n_bad++;
                        $error("FAIL pixel%0d: observed end=%0b data=%0d expected end=%0b data=%0d",
                               n_pix, end_op, data_out, exp1[8], exp1[7:0]);
                    end
                end
                if (n_pix == 0) t_first = cyc;
                t_last = cyc;
                if (end_op) n_end++;
                n_pix++;
            end
        end
    end

    // Monitor for the 4x4 instance.
    always begin
        @(negedge clk);
        if (master_rst_n && valid_op2 && ce) begin
            n_total++;
            assert (q2.size() != 0) else begin
                n_bad++;
                $error("FAIL extra_pixel2: observed data=%0d expected none", data_out2);
            end
            if (q2.size() != 0) begin
                exp2 = q2.pop_front();
                n_total++;
                assert ({end_op2, data_out2} === exp2) else begin
                    n_bad++;
                    $error("FAIL small_pixel%0d: observed end=%0b data=%0d expected end=%0b data=%0d",
                           n_pix2, end_op2, data_out2, exp2[8], exp2[7:0]);
                end
            end
            if (end_op2) n_end2++;
            n_pix2++;
        end
    end

    task automatic push_map(input bit sel, input int mm, input int pp, input int base);
        int w;
        logic [8:0] e;
        w = mm / pp;
        for (int g = 0; g < w; g++)
            for (int r = 0; r < pp; r++)
                for (int c = 0; c < w; c++)
                    for (int rp = 0; rp < pp; rp++) begin
                        e[7:0] = 8'(base + g * w + c);
                        e[8]   = (g == w - 1) && (r == pp - 1) && (c == w - 1) && (rp == pp - 1);
                        if (sel) q2.push_back(e);
                        else     q1.push_back(e);
                    end
    endtask

    // Called and returns at posedge+1.
    task automatic send(input bit sel, input int base, input int n,
                        input int gap_at, input int gap_len);
        bit acc;
        int budget;
        for (int k = 0; k < n; k++) begin
            if (k == gap_at) begin
                if (sel) valid_in2 = 1'b0;
                else     valid_in  = 1'b0;
                repeat (gap_len) begin
                    @(posedge clk);
                    #1;
                end
            end
            if (sel) begin valid_in2 = 1'b1; data_in2 = 8'(base + k); end
            else     begin valid_in  = 1'b1; data_in  = 8'(base + k); end
            acc = 1'b0;
            budget = 0;
            while (!acc && budget < 2000) begin
                @(negedge clk);
                acc = sel ? ready_in2 : ready_in;
                @(posedge clk);
                #1;
                budget++;
            end
            n_total++;
            assert (acc) else begin
                n_bad++;
                $error("FAIL accept_timeout: observed not accepted value %0d expected accepted", base + k);
            end
        end
        valid_in  = 1'b0;
        valid_in2 = 1'b0;
    endtask

    task automatic wait_drain(input string tag);
        int budget;
        budget = 0;
        while ((q1.size() != 0 || q2.size() != 0) && budget < 5000) begin
            @(posedge clk);
            budget++;
        end
        repeat (3) @(posedge clk);
        #1;
        n_total++;
        assert (q1.size() == 0 && q2.size() == 0) else begin
            n_bad++;
            $error("FAIL %s_drain: observed pending=%0d expected 0", tag, q1.size() + q2.size());
        end
    endtask

    task automatic clear_stats();
        n_pix = 0; n_end = 0; t_first = 0; t_last = 0;
        rdy_lo = 0; rdy_hi_bad = 0; n_pix2 = 0; n_end2 = 0;
    endtask

    task automatic check(input string tag, input int obs, input int expv);
        n_total++;
        assert (obs === expv) else begin
            n_bad++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    initial begin
        // Reset state
        #7;
        check("rst_data_out", int'(data_out), 0);
        check("rst_valid_op", int'(valid_op), 0);
        check("rst_end_op",   int'(end_op),   0);
        check("rst_ready_in", int'(ready_in), 0);
        check("rst_valid_op2", int'(valid_op2), 0);
        @(posedge clk);
        #1;
        master_rst_n = 1'b1;
        @(posedge clk);
        #1;

        // 1: full-rate map 1..16
        clear_stats();
        push_map(1'b0, 12, 3, 1);
        send(1'b0, 1, 16, -1, 0);
        wait_drain("t1");
        check("t1_pixels", n_pix, 144);
        check("t1_end_pulses", n_end, 1);
        check("t1_no_bubbles", t_last - t_first, 143);
        check("t1_ready_lo_replay", rdy_lo, 96);
        check("t1_ready_hi_replay", rdy_hi_bad, 0);

        // 2: random ce
        clear_stats();
        ce_rand = 1'b1;
        push_map(1'b0, 12, 3, 1);
        send(1'b0, 1, 16, -1, 0);
        wait_drain("t2");
        ce_rand = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("t2_pixels", n_pix, 144);
        check("t2_end_pulses", n_end, 1);

        // 3: input gap after the 2nd value
        clear_stats();
        push_map(1'b0, 12, 3, 1);
        send(1'b0, 1, 16, 2, 3);
        wait_drain("t3");
        check("t3_pixels", n_pix, 144);
        check("t3_bubble_seen", int'(t_last - t_first > 143), 1);

        // 4: two back-to-back maps
        clear_stats();
        push_map(1'b0, 12, 3, 1);
        push_map(1'b0, 12, 3, 17);
        send(1'b0, 1, 32, -1, 0);
        wait_drain("t4");
        check("t4_pixels", n_pix, 288);
        check("t4_end_pulses", n_end, 2);
        check("t4_ready_lo_replay", rdy_lo, 192);
        check("t4_ready_hi_replay", rdy_hi_bad, 0);

        // 5: reset in the middle of row 4, then a fresh map 9..24
        clear_stats();
        push_map(1'b0, 12, 3, 1);
        send(1'b0, 1, 8, -1, 0);
        for (int b = 0; b < 200 && n_pix < 52; b++) @(posedge clk);
        check("t5_reached_row4", int'(n_pix >= 52), 1);
        #3;
        master_rst_n = 1'b0;
        #1;
        check("t5_rst_valid_op", int'(valid_op), 0);
        check("t5_rst_data_out", int'(data_out), 0);
        check("t5_rst_end_op",   int'(end_op),   0);
        check("t5_rst_ready_in", int'(ready_in), 0);
        q1.delete();
        repeat (2) @(posedge clk);
        #1;
        master_rst_n = 1'b1;
        clear_stats();
        push_map(1'b0, 12, 3, 9);
        send(1'b0, 9, 16, -1, 0);
        wait_drain("t5");
        check("t5_pixels", n_pix, 144);
        check("t5_end_pulses", n_end, 1);

        // 6: small instance, A..D
        clear_stats();
        push_map(1'b1, 4, 2, 8'hA);
        send(1'b1, 8'hA, 4, -1, 0);
        wait_drain("t6");
        check("t6_pixels", n_pix2, 16);
        check("t6_end_pulses", n_end2, 1);

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: observed no completion expected completion");
        $fatal(1, "timeout");
    end

endmodule

`default_nettype wire
